// File: rtl/conv_out_packer_if.sv
// Bundles one column's config, conv result stream and output-SRAM write port.
// The slave modport is the packer; the master side is the upstream controller.
interface conv_out_packer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic [9:0]            ofmap_size_i;
    logic [ADDR_W-1:0]     base_addr_i;
    logic                  relu_en_i;
    logic                  conv_valid_i;
    logic [7:0]            conv_result_i;
    logic                  mem_wr_en_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_wstrb_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport master (
        output start_i, ofmap_size_i, base_addr_i, relu_en_i,
        output conv_valid_i, conv_result_i,
        input  mem_wr_en_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, ofmap_size_i, base_addr_i, relu_en_i,
        input  conv_valid_i, conv_result_i,
        output mem_wr_en_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output busy_o, done_o, err_o
    );
endinterface

// File: rtl/conv_out_packer.sv
// Per-column output stage: optional ReLU, packs four 8-bit results per word
// and writes them to the column's SRAM bank, pulsing done_o after the last word.
module conv_out_packer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_out_packer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              r_state;
    logic [9:0]          r_remaining;
    logic [1:0]          r_bidx;
    logic [DATA_W-1:0]   r_pack;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_relu;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_done;
    logic                r_err;

    logic [7:0]          w_byte;
    logic [DATA_W-1:0]   w_merged;
    logic                w_accept;
    logic                w_flush;
    logic [DATA_W/8-1:0] w_strb;

    // The word being assembled is handed to the write register whole, so the
    // pack register can be cleared and reused the very next cycle.
    always_comb begin
        w_byte   = (r_relu && bus.conv_result_i[7]) ? 8'h00 : bus.conv_result_i;
        w_merged = r_pack;
        w_merged[{r_bidx, 3'b000} +: 8] = w_byte;
        w_accept = (r_state == RUN) && bus.conv_valid_i && (r_remaining != 10'd0);
        w_flush  = (r_bidx == 2'd3) || (r_remaining == 10'd1);
        case (r_bidx)
            2'd0:    w_strb = 4'b0001;
            2'd1:    w_strb = 4'b0011;
            2'd2:    w_strb = 4'b0111;
            default: w_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_bidx      <= '0;
            r_pack      <= '0;
            r_addr      <= '0;
            r_relu      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_err       <= 1'b0;
                        r_remaining <= bus.ofmap_size_i;
                        r_addr      <= bus.base_addr_i;
                        r_relu      <= bus.relu_en_i;
                        r_bidx      <= '0;
                        r_pack      <= '0;
                        if (bus.ofmap_size_i == 10'd0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                    // A result arriving with start is still a drop, so set wins.
                    if (bus.conv_valid_i) r_err <= 1'b1;
                end
                RUN: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 10'd1;
                        if (w_flush) begin
                            r_wr_en    <= 1'b1;
                            r_mem_addr <= r_addr;
                            r_wdata    <= w_merged;
                            r_wstrb    <= w_strb;
                            r_addr     <= r_addr + 1'b1;
                            r_pack     <= '0;
                            r_bidx     <= '0;
                        end else begin
                            r_pack <= w_merged;
                            r_bidx <= r_bidx + 2'd1;
                        end
                    end else if (r_remaining == 10'd0) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    if (bus.conv_valid_i) r_err <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_wr_en_o = r_wr_en;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.mem_wstrb_o = r_wstrb;
    assign bus.busy_o      = (r_state != IDLE);
    assign bus.done_o      = r_done;
    assign bus.err_o       = r_err;

endmodule
